pc_redirect_sequencer: RTL
==========================

Name: pc_redirect_sequencer

Overview:
Sequences program-counter redirects in the 32-bit MIPS pipeline. It arbitrates the branch, J and JR requests in fixed priority and holds a redirect that arrives during a pipeline stall until the stall releases. After each redirect it drives a multi-cycle wrong-path flush. It sits between the decode-stage control/hazard logic and the PC-source mux, and supplies the mux select, the chosen target and the IF/ID flush.

Parameters:
ADDR_W, 32, width of the PC and target addresses
FLUSH_CYCLES, 1, number of un-stalled cycles flush_out stays high after a redirect (legal range 1..15)
CNT_W, 16, width of the redirect statistics counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hazard-unit stall; PC and IF/ID are frozen while high
branch_taken  input  1  a taken conditional branch is resolved in decode
j  input  1  J/JAL is in decode
jr  input  1  JR is in decode
branch_target  input  ADDR_W  branch target address
j_target  input  ADDR_W  jump target address
jr_target  input  ADDR_W  register jump target address
pc_sel  output  2  PC-source select: 00 sequential, 01 branch, 10 J, 11 JR
target_out  output  ADDR_W  registered target that accompanies pc_sel
redirect_valid  output  1  one-cycle pulse marking the cycle in which pc_sel is non-zero
flush_out  output  1  flush IF/ID (squash wrong-path instructions)
pending  output  1  a redirect is held waiting for the stall to release
redirect_count  output  CNT_W  total redirects issued since reset; wraps on overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. pc_sel=00, target_out=0, redirect_valid=0, flush_out=0, pending=0, redirect_count=0, flush counter=0. A reset mid-HOLD or mid-FLUSH discards the held redirect and any remaining flush.
- Request priority: branch_taken > j > jr. The encoded select is 01, 10 or 11 respectively, and the target is taken from the matching input. req_any = branch_taken | j | jr.
- All outputs are registered. A redirect accepted in cycle N appears on pc_sel, target_out and redirect_valid in cycle N+1, for exactly one cycle. pc_sel returns to 00 in the following cycle. target_out holds its last value.
- States:
  - IDLE:
    - req_any & !stall: issue the redirect at the next edge and go to FLUSH.
    - req_any & stall: latch the encoded select and target, set pending=1, go to HOLD.
    - otherwise stay in IDLE.
  - HOLD:
    - Requests are ignored; the latched select and target are kept.
    - When stall=0: issue the latched redirect at the next edge, clear pending, go to FLUSH.
  - FLUSH:
    - flush_out=1 from the redirect_valid cycle onward.
    - The counter loads FLUSH_CYCLES on issue and decrements once per cycle with stall=0.
    - While stall=1 the counter freezes and flush_out stays 1.
    - When the counter reaches 0, go to IDLE; flush_out deasserts in that same registered update.
    - Requests are ignored, because they come from wrong-path instructions.
- redirect_count increments by 1 in each cycle that redirect_valid is 1. It wraps from 2^CNT_W-1 to 0.
- Simultaneous requests: only the highest-priority request is issued. The lower ones are dropped, not queued.
- A stall asserting in the same cycle as the issue edge does not cancel or delay the redirect. It only freezes the flush counter.
- pending=1 only in HOLD. redirect_valid and pending are never 1 together.

Test Plan:
- Reset: hold rst_n=0 with all requests high -> all outputs 0. Release reset with no requests -> pc_sel stays 00 and redirect_valid stays 0 for 10 cycles.
- Priority: branch_taken=j=jr=1 for one cycle with stall=0, branch_target=0x00400020 -> next cycle pc_sel=01, target_out=0x00400020, redirect_valid=1, flush_out=1, redirect_count=1. No second redirect follows.
- Stalled redirect: jr=1, jr_target=0x00400100 with stall=1 held for 3 cycles -> pending=1 and pc_sel=00 throughout. Cycle after stall drops -> pc_sel=11, target_out=0x00400100, pending=0.
- Flush length: FLUSH_CYCLES=2, J issued, then stall=1 for 2 cycles inside the flush window -> flush_out high for 4 cycles total. A j request during the flush is ignored (redirect_count unchanged).
- Counter wrap: CNT_W=4, issue 17 redirects with idle gaps between them -> redirect_count reads 1.
- Asynchronous reset mid-HOLD: assert rst_n=0 between clock edges while pending=1 -> pending and pc_sel clear immediately. After release, no redirect is issued.

Source files
------------

// File: rtl/pc_redirect_if.sv
// Decode-side request bundle and PC-source mux controls for the redirect sequencer.
interface pc_redirect_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              branch_taken;
  logic              j;
  logic              jr;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_target;
  logic [1:0]        pc_sel;
  logic [ADDR_W-1:0] target_out;
  logic              redirect_valid;
  logic              flush_out;
  logic              pending;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    output stall, branch_taken, j, jr, branch_target, j_target, jr_target,
    input  pc_sel, target_out, redirect_valid, flush_out, pending, redirect_count
  );

  modport slave (
    input  stall, branch_taken, j, jr, branch_target, j_target, jr_target,
    output pc_sel, target_out, redirect_valid, flush_out, pending, redirect_count
  );
endinterface

// File: rtl/pc_redirect_sequencer.sv
// Arbitrates branch/J/JR redirects, holds them across stalls and drives a
// multi-cycle wrong-path flush of IF/ID after each issued redirect.
module pc_redirect_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rst_n,
  pc_redirect_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [1:0]        pc_sel_q, pc_sel_nx;
  logic [ADDR_W-1:0] target_q, target_nx;
  logic              valid_q, valid_nx;
  logic              flush_q, flush_nx;
  logic              pending_q, pending_nx;
  logic [CNT_W-1:0]  count_q, count_nx;
  logic [3:0]        fcnt_q, fcnt_nx;
  logic [1:0]        hold_sel_q, hold_sel_nx;
  logic [ADDR_W-1:0] hold_tgt_q, hold_tgt_nx;

  logic              req_any;
  logic [1:0]        req_sel;
  logic [ADDR_W-1:0] req_tgt;
  logic              issue;
  logic [1:0]        issue_sel;
  logic [ADDR_W-1:0] issue_tgt;

  assign req_any = bus.branch_taken | bus.j | bus.jr;

  // Fixed priority: branch over J over JR; lower requests are simply dropped.
  always_comb begin
    req_sel = 2'b00;
    req_tgt = '0;
    if (bus.branch_taken) begin
      req_sel = 2'b01;
      req_tgt = bus.branch_target;
    end else if (bus.j) begin
      req_sel = 2'b10;
      req_tgt = bus.j_target;
    end else if (bus.jr) begin
      req_sel = 2'b11;
      req_tgt = bus.jr_target;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_sel_nx   = 2'b00;
    target_nx   = target_q;
    valid_nx    = 1'b0;
    flush_nx    = flush_q;
    pending_nx  = 1'b0;
    count_nx    = count_q;
    fcnt_nx     = fcnt_q;
    hold_sel_nx = hold_sel_q;
    hold_tgt_nx = hold_tgt_q;
    issue       = 1'b0;
    issue_sel   = req_sel;
    issue_tgt   = req_tgt;

    case (state)
      IDLE: begin
        if (req_any) begin
          if (!bus.stall) begin
            issue = 1'b1;
          end else begin
            hold_sel_nx = req_sel;
            hold_tgt_nx = req_tgt;
            pending_nx  = 1'b1;
            state_nx    = HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          issue     = 1'b1;
          issue_sel = hold_sel_q;
          issue_tgt = hold_tgt_q;
        end else begin
          pending_nx = 1'b1;
        end
      end
      FLUSH: begin
        // Requests seen here belong to wrong-path instructions and are ignored.
        if (!bus.stall) begin
          if (fcnt_q <= 4'd1) begin
            fcnt_nx  = 4'd0;
            flush_nx = 1'b0;
            state_nx = IDLE;
          end else begin
            fcnt_nx = fcnt_q - 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (issue) begin
      pc_sel_nx = issue_sel;
      target_nx = issue_tgt;
      valid_nx  = 1'b1;
      flush_nx  = 1'b1;
      fcnt_nx   = FLUSH_LOAD;
      count_nx  = count_q + CNT_ONE;
      state_nx  = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_sel_q   <= 2'b00;
      target_q   <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      fcnt_q     <= 4'd0;
      hold_sel_q <= 2'b00;
      hold_tgt_q <= '0;
    end else begin
      state      <= state_nx;
      pc_sel_q   <= pc_sel_nx;
      target_q   <= target_nx;
      valid_q    <= valid_nx;
      flush_q    <= flush_nx;
      pending_q  <= pending_nx;
      count_q    <= count_nx;
      fcnt_q     <= fcnt_nx;
      hold_sel_q <= hold_sel_nx;
      hold_tgt_q <= hold_tgt_nx;
    end
  end

  assign bus.pc_sel         = pc_sel_q;
  assign bus.target_out     = target_q;
  assign bus.redirect_valid = valid_q;
  assign bus.flush_out      = flush_q;
  assign bus.pending        = pending_q;
  assign bus.redirect_count = count_q;
endmodule
